// File: rtl/pattern_detect_n_if.sv
// Serial stream, configuration and result bundle for pattern_detect_n.
// Optional macro PATTERN_DETECT_N_COUNT_EN adds cnt_clr / match_count.
//   master : stream source / controller (drives din, cfg_*, cnt_clr)
//   slave  : the detector (drives match, armed, match_count)
interface pattern_detect_n_if #(
  parameter int unsigned PAT_W = 8
`ifdef PATTERN_DETECT_N_COUNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic             din;
  logic             din_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             match;
  logic             armed;
`ifdef PATTERN_DETECT_N_COUNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] match_count;
`endif

  modport master (
    output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef PATTERN_DETECT_N_COUNT_EN
    output cnt_clr,
    input  match_count,
`endif
    input  match, armed
  );

  modport slave (
    input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef PATTERN_DETECT_N_COUNT_EN
    input  cnt_clr,
    output match_count,
`endif
    output match, armed
  );
endinterface

// File: rtl/pattern_detect_n.sv
// Runtime-programmable serial pattern detector (1..PAT_W bits, overlapping or
// non-overlapping), with a one-cycle match pulse and an armed flag.
// Optional macro PATTERN_DETECT_N_COUNT_EN compiles in a saturating match
// counter (bus.cnt_clr in, bus.match_count out).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : pattern_detect_n_if.slave (din/din_valid, cfg_*, match, armed,
//           and optionally cnt_clr/match_count)
module pattern_detect_n #(
  parameter int unsigned      PAT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0000_0111),
  parameter int unsigned      LEN_RST = 3
`ifdef PATTERN_DETECT_N_COUNT_EN
  ,
  parameter int unsigned      CNT_W   = 8
`endif
) (
  input logic               clk,
  input logic               reset,
  pattern_detect_n_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t           state;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             match_q;
  logic             armed_q;

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] len_clamp;
  logic             hit;
  logic             arm_now;
  logic             match_set;

  // The oldest history bit is shifted out without ever being compared.
  logic unused_hist_msb;
  assign unused_hist_msb = hist[PAT_W-1];

  // Next history, length mask, compare result and clamped config length.
  always_comb begin
    hist_shift = {hist[PAT_W-2:0], bus.din};
    fill_inc   = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len));
    end
    hit = (((hist_shift ^ pat) & mask) == '0);
    // The bit that brings fill up to len is itself compared.
    arm_now   = (state == ARMED) || (fill_inc >= len);
    match_set = !bus.cfg_load && bus.din_valid && arm_now && hit;
    if (bus.cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(PAT_W)) begin
      len_clamp = LEN_W'(PAT_W);
    end else begin
      len_clamp = bus.cfg_len;
    end
  end

  // Detector FSM with history, fill counter and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pat     <= PAT_RST;
      len     <= LEN_W'(LEN_RST);
      overlap <= 1'b1;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (bus.cfg_load) begin
        // Config load restarts detection; a simultaneous valid bit is dropped.
        pat     <= bus.cfg_pattern;
        len     <= len_clamp;
        overlap <= bus.cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        state   <= FILL;
        armed_q <= 1'b0;
      end else if (bus.din_valid) begin
        case (state)
          FILL: begin
            if (arm_now && hit && !overlap) begin
              hist    <= '0;
              fill    <= '0;
              match_q <= 1'b1;
            end else if (arm_now) begin
              hist    <= hist_shift;
              fill    <= fill_inc;
              state   <= ARMED;
              armed_q <= 1'b1;
              match_q <= hit;
            end else begin
              hist <= hist_shift;
              fill <= fill_inc;
            end
          end
          ARMED: begin
            if (hit && !overlap) begin
              hist    <= '0;
              fill    <= '0;
              state   <= FILL;
              armed_q <= 1'b0;
              match_q <= 1'b1;
            end else begin
              hist    <= hist_shift;
              fill    <= fill_inc;
              match_q <= hit;
            end
          end
          default: begin
            state   <= FILL;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.match = match_q;
  assign bus.armed = armed_q;

`ifdef PATTERN_DETECT_N_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Saturating match counter; clear wins over a same-edge increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.cnt_clr) begin
      cnt <= '0;
    end else if (match_set && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.match_count = cnt;
`else
  logic unused_match_set;
  assign unused_match_set = match_set;
`endif
endmodule

// File: tb/tb_pattern_detect_n.sv
// Self-checking bench for pattern_detect_n: directed vector table followed by
// randomized stimulus checked against a queue-based reference model.
module tb_pattern_detect_n;
  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  pattern_detect_n_if #(
    .PAT_W(PAT_W)
`ifdef PATTERN_DETECT_N_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  pattern_detect_n #(
    .PAT_W(PAT_W)
`ifdef PATTERN_DETECT_N_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         load;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ov;
    bit         clr;
    bit         valid;
    bit         din;
    bit         em;
    bit         ea;
    int         ec;   // -1: count not checked
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the last received bits since the last clear, oldest first.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;
  int         m_cnt;
  bit         m_match;
  bit         m_armed;

  task automatic model_step(input vec_t v);
    bit hit;
    hit = 1'b0;
    if (v.rst) begin
      q.delete();
      m_pat = 8'b0000_0111;
      m_len = 3;
      m_ov  = 1'b1;
      m_cnt = 0;
    end else begin
      if (v.load) begin
        q.delete();
        m_pat = v.pat;
        m_len = int'(v.len);
        if (m_len < 1) m_len = 1;
        if (m_len > PAT_W) m_len = PAT_W;
        m_ov = v.ov;
      end else if (v.valid) begin
        q.push_back(v.din);
        if (q.size() > PAT_W) void'(q.pop_front());
        if (q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++) begin
            if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
          end
          if (hit && !m_ov) q.delete();
        end
      end
      if (v.clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
    end
    m_match = hit;
    m_armed = (q.size() >= m_len);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset           = v.rst;
    bus.cfg_load    = v.load;
    bus.cfg_pattern = v.pat;
    bus.cfg_len     = v.len;
    bus.cfg_overlap = v.ov;
    bus.din_valid   = v.valid;
    bus.din         = v.din;
`ifdef PATTERN_DETECT_N_COUNT_EN
    bus.cnt_clr     = v.clr;
`endif
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic add(input bit rst, input bit load, input logic [7:0] pat,
                     input logic [3:0] len, input bit ov, input bit clr,
                     input bit valid, input bit din, input bit em,
                     input bit ea, input int ec);
    vec_t v;
    v.rst = rst; v.load = load; v.pat = pat; v.len = len; v.ov = ov;
    v.clr = clr; v.valid = valid; v.din = din; v.em = em; v.ea = ea; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic ld(input logic [7:0] pat, input logic [3:0] len, input bit ov,
                    input bit clr, input int ec);
    add(0, 1, pat, len, ov, clr, 0, 0, 0, 0, ec);
  endtask

  task automatic bt(input bit din, input bit em, input bit ea, input int ec);
    add(0, 0, 8'h00, 4'd0, 0, 0, 1, din, em, ea, ec);
  endtask

  task automatic idle(input bit ea, input int ec);
    add(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, ea, ec);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
`ifdef PATTERN_DETECT_N_COUNT_EN
    bus.cnt_clr = 1'b0;
`endif

    // Reset defaults: legacy three-ones behaviour, overlapping.
    add(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    bt(1, 0, 0, 0); bt(1, 0, 0, 0); bt(1, 1, 1, 1); bt(1, 1, 1, 2); bt(1, 1, 1, 3);
    // Non-overlap 111.
    ld(8'b0000_0111, 4'd3, 0, 1, 0);
    bt(1, 0, 0, 0); bt(1, 0, 0, 0); bt(1, 1, 0, 1);
    bt(1, 0, 0, 1); bt(1, 0, 0, 1); bt(1, 1, 0, 2);
    // Overlap with internal prefix: 1011 in 1011011.
    ld(8'b0000_1011, 4'd4, 1, 1, 0);
    bt(1, 0, 0, 0); bt(0, 0, 0, 0); bt(1, 0, 0, 0); bt(1, 1, 1, 1);
    bt(0, 0, 1, 1); bt(1, 0, 1, 1); bt(1, 1, 1, 2);
    // Idle gaps do not break a sequence.
    ld(8'b0000_0111, 4'd3, 1, 1, 0);
    bt(1, 0, 0, 0); bt(1, 0, 0, 0); idle(0, 0); idle(0, 0); bt(1, 1, 1, 1);
    // cfg_load beats din_valid and restarts the fill.
    ld(8'b0000_0111, 4'd3, 1, 0, 1);
    bt(1, 0, 0, 1); bt(1, 0, 0, 1);
    add(0, 1, 8'b0000_0111, 4'd3, 1, 0, 1, 1, 0, 0, 1);
    bt(1, 0, 0, 1); bt(1, 0, 0, 1); bt(1, 1, 1, 2);
    // cfg_len=0 clamps to 1: match on every bit, counter saturates.
    ld(8'b0000_0001, 4'd0, 1, 1, 0);
    bt(1, 1, 1, 1); bt(1, 1, 1, 2); bt(1, 1, 1, 3); bt(1, 1, 1, 3);
    bt(1, 1, 1, 3); bt(1, 1, 1, 3); bt(1, 1, 1, 3); bt(1, 1, 1, 3);
    // Clear wins over a simultaneous match.
    add(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1, 0);
    // cfg_len above PAT_W clamps to PAT_W.
    ld(8'hFF, 4'd15, 1, 0, 0);
    for (int i = 0; i < 7; i++) bt(1, 0, 0, 0);
    bt(1, 1, 1, 1);
    // Reset on the completing edge suppresses the match; defaults return.
    ld(8'b0000_0001, 4'd3, 0, 0, 1);
    bt(0, 0, 0, 1); bt(0, 0, 0, 1);
    add(1, 0, 8'h00, 4'd0, 0, 0, 1, 1, 0, 0, 0);
    bt(1, 0, 0, 0); bt(1, 0, 0, 0); bt(1, 1, 1, 1); bt(1, 1, 1, 2);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d_match", i), int'(bus.match), int'(vecs[i].em));
      check($sformatf("vec%0d_armed", i), int'(bus.armed), int'(vecs[i].ea));
`ifdef PATTERN_DETECT_N_COUNT_EN
      if (vecs[i].ec >= 0)
        check($sformatf("vec%0d_count", i), int'(bus.match_count), vecs[i].ec);
`endif
    end

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(0, 299) == 0);
      v.load  = ($urandom_range(0, 24) == 0);
      v.pat   = 8'($urandom);
      v.len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 4));
      v.ov    = 1'($urandom);
      v.clr   = ($urandom_range(0, 39) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.din   = 1'($urandom);
      v.em = 1'b0; v.ea = 1'b0; v.ec = -1;
      drive(v);
      check($sformatf("rnd%0d_match", n), int'(bus.match), int'(m_match));
      check($sformatf("rnd%0d_armed", n), int'(bus.armed), int'(m_armed));
`ifdef PATTERN_DETECT_N_COUNT_EN
      check($sformatf("rnd%0d_count", n), int'(bus.match_count), m_cnt);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
